// File: rtl/ascensor_ctrl_n.sv
// Parametrised SCAN elevator controller: latches one-hot floor requests,
// travels with a per-floor timer and holds the doors open for a timed dwell.
module ascensor_ctrl_n #(
    parameter int N_PISOS      = 4,
    parameter int T_VIAJE      = 8,
    parameter int T_PUERTA     = 16,
    parameter int PISO_INICIAL = 0,
    localparam int W           = (N_PISOS > 1) ? $clog2(N_PISOS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_PISOS-1:0] req,
    output logic [W-1:0]       piso,
    output logic [1:0]         accion,
    output logic               puertas,
    output logic [N_PISOS-1:0] pend
);

    localparam int T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
    localparam int TW    = $clog2(T_MAX) + 1;

    localparam logic [1:0] ACC_PARADO   = 2'b00;
    localparam logic [1:0] ACC_SUBIENDO = 2'b01;
    localparam logic [1:0] ACC_BAJANDO  = 2'b10;
    localparam logic [1:0] ACC_PUERTAS  = 2'b11;

    typedef enum logic [1:0] {REPOSO, SUBIENDO, BAJANDO, PUERTA} estado_t;

    estado_t             estado;
    logic                dir_sube;
    logic [TW-1:0]       timer;

    logic [W-1:0]        piso_sig;
    logic [N_PISOS-1:0]  pm;
    logic [N_PISOS-1:0]  uno_piso;
    logic [N_PISOS-1:0]  uno_sig;
    logic                hay_arriba;
    logic                hay_abajo;
    logic                sig_arriba;
    logic                sig_abajo;

    function automatic logic hay_sobre(input logic [N_PISOS-1:0] v, input logic [W-1:0] p);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < N_PISOS; i++)
            if (i > 32'(p)) r = r | v[i];
        return r;
    endfunction

    function automatic logic hay_bajo(input logic [N_PISOS-1:0] v, input logic [W-1:0] p);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < N_PISOS; i++)
            if (i < 32'(p)) r = r | v[i];
        return r;
    endfunction

    // Idle decisions use the latched vector; arrival decisions also see this cycle's req.
    always_comb begin
        piso_sig   = (estado == BAJANDO) ? piso - 1'b1 : piso + 1'b1;
        pm         = pend | req;
        uno_piso   = N_PISOS'(1) << piso;
        uno_sig    = N_PISOS'(1) << piso_sig;
        hay_arriba = hay_sobre(pend, piso);
        hay_abajo  = hay_bajo(pend, piso);
        sig_arriba = hay_sobre(pm, piso_sig);
        sig_abajo  = hay_bajo(pm, piso_sig);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= REPOSO;
            dir_sube <= 1'b1;
            timer    <= '0;
            piso     <= W'(PISO_INICIAL);
            accion   <= ACC_PARADO;
            puertas  <= 1'b0;
            pend     <= '0;
        end else if (en) begin
            case (estado)
                REPOSO: begin
                    if (pend[piso]) begin
                        estado  <= PUERTA;
                        timer   <= TW'(T_PUERTA - 1);
                        accion  <= ACC_PUERTAS;
                        puertas <= 1'b1;
                        pend    <= pm & ~uno_piso;
                    end else begin
                        pend <= pm;
                        if (hay_arriba && (dir_sube || !hay_abajo)) begin
                            estado   <= SUBIENDO;
                            dir_sube <= 1'b1;
                            timer    <= TW'(T_VIAJE - 1);
                            accion   <= ACC_SUBIENDO;
                        end else if (hay_abajo) begin
                            estado   <= BAJANDO;
                            dir_sube <= 1'b0;
                            timer    <= TW'(T_VIAJE - 1);
                            accion   <= ACC_BAJANDO;
                        end
                    end
                end
                SUBIENDO, BAJANDO: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                        pend  <= pm;
                    end else begin
                        piso <= piso_sig;
                        if (pm[piso_sig]) begin
                            estado  <= PUERTA;
                            timer   <= TW'(T_PUERTA - 1);
                            accion  <= ACC_PUERTAS;
                            puertas <= 1'b1;
                            pend    <= pm & ~uno_sig;
                        end else begin
                            pend <= pm;
                            if ((estado == SUBIENDO) ? sig_arriba : sig_abajo) begin
                                timer <= TW'(T_VIAJE - 1);
                            end else begin
                                estado <= REPOSO;
                                accion <= ACC_PARADO;
                            end
                        end
                    end
                end
                PUERTA: begin
                    // A press for the open floor only extends the dwell.
                    pend <= pm & ~uno_piso;
                    if (req[piso]) begin
                        timer <= TW'(T_PUERTA - 1);
                    end else if (timer == '0) begin
                        estado  <= REPOSO;
                        accion  <= ACC_PARADO;
                        puertas <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    estado  <= REPOSO;
                    accion  <= ACC_PARADO;
                    puertas <= 1'b0;
                end
            endcase
        end
    end

endmodule
